// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port word memory between fetch (I) and load/store (D).
// Define MEM_MISALIGN_CHK_EN to add d_err and suppress misaligned data accesses.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic [ADDR_W-1:0] mem_A,
    output logic [DATA_W-1:0] mem_WD,
    output logic              mem_We,
    input  logic [DATA_W-1:0] mem_RD,
    output logic              busy
`ifdef MEM_MISALIGN_CHK_EN
    ,
    output logic              d_err
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [3:0] CNT_INIT   = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [3:0]          starve_q, starve_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                d_win;
    logic                blk;

`ifdef MEM_MISALIGN_CHK_EN
    logic err_q, err_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    always_comb begin
        err_d = err_q;
        if (state_q == IDLE && (i_req || d_req)) begin
            err_d = d_win && (d_addr[1:0] != 2'b00);
        end
    end

    assign blk   = err_q;
    assign d_err = (state_q == DONE) && owner_q && err_q;
`else
    assign blk = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            cnt_q     <= 4'd0;
            starve_q  <= 4'd0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            starve_q  <= starve_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // owner_q: 1 = data port, 0 = fetch port
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        starve_d  = starve_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        d_win     = d_req && !(i_req && starve_q == STARVE_LIM);
        unique case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    if (d_win) begin
                        owner_d = 1'b1;
                        addr_d  = d_addr;
                        we_d    = d_we;
                        wdata_d = d_wdata;
                        if (i_req && starve_q != 4'hF) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end else begin
                        owner_d  = 1'b0;
                        addr_d   = i_addr;
                        we_d     = 1'b0;
                        starve_d = 4'd0;
                    end
                    cnt_d   = CNT_INIT;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (!we_q && !blk) begin
                        if (owner_q) begin
                            d_rdata_d = mem_RD;
                        end else begin
                            i_rdata_d = mem_RD;
                        end
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_A   = addr_q;
    assign mem_WD  = wdata_q;
    assign mem_We  = (state_q == RUN) && (cnt_q == 4'd0) && we_q && !blk;
    assign i_ack   = (state_q == DONE) && !owner_q;
    assign d_ack   = (state_q == DONE) && owner_q;
    assign busy    = (state_q != IDLE);
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter with a transaction-level model.
// Build with MEM_MISALIGN_CHK_EN to exercise d_err.
module tb_mem_port_arbiter;

    localparam int LAT  = 2;
    localparam int SMAX = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic        mem_We;
    logic [31:0] mem_RD;
    logic        busy;
`ifdef MEM_MISALIGN_CHK_EN
    logic        d_err;
`endif

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_A(mem_A), .mem_WD(mem_WD), .mem_We(mem_We), .mem_RD(mem_RD),
        .busy(busy)
`ifdef MEM_MISALIGN_CHK_EN
        , .d_err(d_err)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];

    assign mem_RD = mem[mem_A[9:2]];
    always @(posedge clk) if (mem_We) mem[mem_A[9:2]] <= mem_WD;

    int total = 0;
    int bad = 0;

    // transaction model: m_busy counts remaining RUN+DONE cycles
    int          m_busy;
    bit          m_own_d;
    bit          m_we;
    logic [31:0] m_addr, m_wd, m_irdata, m_drdata;
    int          m_starve;

    task automatic model_reset();
        m_busy = 0; m_own_d = 0; m_we = 0;
        m_addr = '0; m_wd = '0;
        m_irdata = '0; m_drdata = '0;
        m_starve = 0;
    endtask

    function automatic bit m_blk();
`ifdef MEM_MISALIGN_CHK_EN
        return m_own_d && (m_addr[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else if (m_busy == 0) begin
            if (i_req || d_req) begin
                if (d_req && !(i_req && m_starve == SMAX)) begin
                    m_own_d = 1; m_we = d_we;
                    m_addr = d_addr; m_wd = d_wdata;
                    if (i_req && m_starve < 15) m_starve++;
                end else begin
                    m_own_d = 0; m_we = 0; m_addr = i_addr;
                    m_starve = 0;
                end
                m_busy = LAT + 1;
            end
        end else begin
            if (m_busy == 2 && !m_blk()) begin
                if (m_we) ref_mem[m_addr[9:2]] = m_wd;
                else if (m_own_d) m_drdata = ref_mem[m_addr[9:2]];
                else m_irdata = ref_mem[m_addr[9:2]];
            end
            m_busy--;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] orig;
        orig = mem[2];
        #1 rst = 1'b0;
        #1;
        total++;
        if ({i_ack, d_ack, mem_We, busy} !== 4'b0) begin
            bad++; $display("FAIL reset_ctl: got %b want 0000", {i_ack, d_ack, mem_We, busy});
        end
        total++;
        if ({i_rdata, d_rdata, mem_A, mem_WD} !== 128'b0) begin
            bad++; $display("FAIL reset_data: got %h want 0", {i_rdata, d_rdata, mem_A, mem_WD});
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        d_req = 1; d_we = 1; d_addr = 32'h8; d_wdata = 32'hDEADBEEF;
        tick();
        tick();
        total++;
        if (mem_We !== 1'b1 || mem_A !== 32'h8) begin
            bad++; $display("FAIL store_pre_abort: got we=%b a=%h want we=1 a=8", mem_We, mem_A);
        end
        #1 rst = 1'b0;
        #1;
        total++;
        if ({mem_We, busy, d_ack} !== 3'b0 || {mem_A, mem_WD} !== 64'b0) begin
            bad++; $display("FAIL reset_abort: got we=%b busy=%b a=%h wd=%h want 0", mem_We, busy, mem_A, mem_WD);
        end
        model_reset();
        d_req = 0; d_we = 0;
        tick();
        rst = 1'b1;
        tick();
        total++;
        if (mem[2] !== orig) begin
            bad++; $display("FAIL reset_mem2: got %h want %h", mem[2], orig);
        end
    endtask

    task automatic test_fetch();
        int lat = 0;
        int bcnt = 0;
        mem[1] = 32'h00500093; ref_mem[1] = 32'h00500093;
        i_req = 1; i_addr = 32'h4;
        for (int c = 0; c < 12 && lat == 0; c++) begin
            tick();
            if (busy) bcnt++;
            if (i_ack) begin
                lat = c + 1; i_req = 0;
                total++;
                if (i_rdata !== 32'h00500093) begin
                    bad++; $display("FAIL fetch_data: got %h want 00500093", i_rdata);
                end
            end
        end
        total++;
        if (lat != LAT + 1) begin
            bad++; $display("FAIL fetch_latency: got %0d want %0d", lat, LAT + 1);
        end
        total++;
        if (bcnt != LAT + 1) begin
            bad++; $display("FAIL fetch_busy: got %0d want %0d", bcnt, LAT + 1);
        end
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL fetch_idle: got %b want 0", busy);
        end
    endtask

    task automatic test_store_load();
        int pulses = 0;
        bit got = 0;
        d_req = 1; d_we = 1; d_addr = 32'hC; d_wdata = 32'h12345678;
        for (int c = 0; c < 12 && !got; c++) begin
            tick();
            if (mem_We) begin
                pulses++;
                total++;
                if (mem_A !== 32'hC || mem_WD !== 32'h12345678) begin
                    bad++; $display("FAIL store_bus: got a=%h wd=%h want c/12345678", mem_A, mem_WD);
                end
            end
            if (d_ack) begin got = 1; d_req = 0; end
        end
        total++;
        if (pulses != 1 || !got) begin
            bad++; $display("FAIL store_pulse: got pulses=%0d ack=%0d want 1/1", pulses, got);
        end
        tick();
        d_req = 1; d_we = 0; got = 0;
        for (int c = 0; c < 12 && !got; c++) begin
            tick();
            if (d_ack) begin
                got = 1; d_req = 0;
                total++;
                if (d_rdata !== 32'h12345678) begin
                    bad++; $display("FAIL load_data: got %h want 12345678", d_rdata);
                end
            end
        end
        total++;
        if (!got) begin
            bad++; $display("FAIL load_ack: got 0 want 1");
        end
    endtask

    task automatic test_contention();
        int n = 0;
        int last = 0;
        bit seq[6];
        bit exp_seq[6];
        exp_seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        i_req = 1; i_addr = 32'h20;
        d_req = 1; d_we = 0; d_addr = 32'h24;
        for (int c = 0; c < 60 && n < 6; c++) begin
            tick();
            if (i_ack || d_ack) begin
                if (n > 0) begin
                    total++;
                    if (c - last != LAT + 2) begin
                        bad++; $display("FAIL contend_gap: got %0d want %0d", c - last, LAT + 2);
                    end
                end
                last = c;
                seq[n] = d_ack;
                n++;
                if (n == 6) begin i_req = 0; d_req = 0; end
            end
        end
        i_req = 0; d_req = 0;
        total++;
        if (n != 6) begin
            bad++; $display("FAIL contend_count: got %0d want 6", n);
        end
        for (int k = 0; k < n; k++) begin
            total++;
            if (seq[k] !== exp_seq[k]) begin
                bad++; $display("FAIL contend_order[%0d]: got d=%0d want d=%0d", k, seq[k], exp_seq[k]);
            end
        end
        tick();
    endtask

    task automatic test_drop();
        int da = 0, we = 0, ia = 0;
        logic [31:0] keep;
        keep = ref_mem[8'h11];
        i_req = 1; i_addr = 32'h40;
        tick();
        d_req = 1; d_we = 1; d_addr = 32'h44; d_wdata = 32'hA5A5A5A5;
        tick();
        d_req = 0; d_we = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (d_ack) da++;
            if (mem_We) we++;
            if (i_ack) begin ia++; i_req = 0; end
        end
        total++;
        if (da != 0 || we != 0 || ia != 1) begin
            bad++; $display("FAIL drop: got dack=%0d we=%0d iack=%0d want 0/0/1", da, we, ia);
        end
        total++;
        if (mem[8'h11] !== keep) begin
            bad++; $display("FAIL drop_mem: got %h want %h", mem[8'h11], keep);
        end
    endtask

`ifdef MEM_MISALIGN_CHK_EN
    task automatic test_misalign();
        int pulses = 0;
        bit got = 0;
        d_req = 1; d_we = 1; d_addr = 32'h6; d_wdata = 32'hCAFEF00D;
        for (int c = 0; c < 12 && !got; c++) begin
            tick();
            if (mem_We) pulses++;
            if (d_ack) begin
                got = 1; d_req = 0;
                total++;
                if (d_err !== 1'b1) begin
                    bad++; $display("FAIL misalign_err: got %b want 1", d_err);
                end
            end else begin
                total++;
                if (d_err !== 1'b0) begin
                    bad++; $display("FAIL misalign_err_idle: got %b want 0", d_err);
                end
            end
        end
        total++;
        if (pulses != 0 || !got) begin
            bad++; $display("FAIL misalign_we: got pulses=%0d ack=%0d want 0/1", pulses, got);
        end
        tick();
        d_req = 1; d_we = 0; d_addr = 32'h8; got = 0;
        for (int c = 0; c < 12 && !got; c++) begin
            tick();
            if (d_ack) begin
                got = 1; d_req = 0;
                total++;
                if (d_err !== 1'b0 || d_rdata !== ref_mem[2]) begin
                    bad++; $display("FAIL align_load: got err=%b d=%h want 0/%h", d_err, d_rdata, ref_mem[2]);
                end
            end
        end
        total++;
        if (!got) begin
            bad++; $display("FAIL align_ack: got 0 want 1");
        end
    endtask
`endif

    task automatic test_random();
        bit ei, ed, ew, allow;
        for (int c = 0; c < 600; c++) begin
            tick();
            ei = (m_busy == 1) && !m_own_d;
            ed = (m_busy == 1) && m_own_d;
            ew = (m_busy == 2) && m_we && !m_blk();
            total++;
            if ({busy, i_ack, d_ack, mem_We} !== {m_busy != 0, ei, ed, ew}) begin
                bad++; $display("FAIL rnd_ctl @%0d: got %b want %b", c,
                    {busy, i_ack, d_ack, mem_We}, {m_busy != 0, ei, ed, ew});
            end
            if (m_busy != 0) begin
                total++;
                if (mem_A !== m_addr) begin
                    bad++; $display("FAIL rnd_addr @%0d: got %h want %h", c, mem_A, m_addr);
                end
            end
            if (ew) begin
                total++;
                if (mem_WD !== m_wd) begin
                    bad++; $display("FAIL rnd_wd @%0d: got %h want %h", c, mem_WD, m_wd);
                end
            end
            total++;
            if (i_rdata !== m_irdata || d_rdata !== m_drdata) begin
                bad++; $display("FAIL rnd_rdata @%0d: got %h/%h want %h/%h", c,
                    i_rdata, d_rdata, m_irdata, m_drdata);
            end
`ifdef MEM_MISALIGN_CHK_EN
            total++;
            if (d_err !== 1'b0) begin
                bad++; $display("FAIL rnd_err @%0d: got %b want 0", c, d_err);
            end
`endif
            allow = (c < 570);
            if (i_ack) i_req = 0;
            else if (!i_req && allow && $urandom_range(0, 2) == 0) begin
                i_req = 1;
                i_addr = 32'($urandom_range(0, 255)) << 2;
            end
            if (d_ack) d_req = 0;
            else if (!d_req && allow && $urandom_range(0, 2) == 0) begin
                d_req = 1;
                d_we = 1'($urandom_range(0, 1));
                d_addr = 32'($urandom_range(0, 255)) << 2;
                d_wdata = $urandom;
            end
        end
        total++;
        if (busy !== 1'b0 || i_req || d_req) begin
            bad++; $display("FAIL rnd_drain: got busy=%b ireq=%b dreq=%b want 0", busy, i_req, d_req);
        end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) begin
            mem[k] = $urandom;
            ref_mem[k] = mem[k];
        end
        model_reset();
        test_reset();
        test_fetch();
        test_store_load();
        test_contention();
        test_drop();
`ifdef MEM_MISALIGN_CHK_EN
        test_misalign();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
